// File: rtl/flash_arb_pkg.sv
// flash_arb_pkg: shared types and helpers for the flash port arbiter.
package flash_arb_pkg;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    // One outstanding response: who owns it, what kind, and whether it
    // is already known to be an error before the flash answers.
    typedef struct packed {
        logic  valid;
        port_e port;
        logic  is_write;
        logic  err;
    } rsp_tag_t;

    // Expands one byte-enable bit into the eight mask bits of that byte lane.
    function automatic logic [7:0] be_to_bitmask(input logic be);
        return {8{be}};
    endfunction

endpackage

// File: rtl/flash_rr_arb.sv
// flash_rr_arb: two-input round-robin arbiter. On contention the port that
// was not granted most recently wins; the pointer only moves on a grant.
module flash_rr_arb (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // ptr names the port that wins the next contention
    logic ptr_d;
    logic ptr_q;

    // Grant decision and pointer update; grants are held off during reset.
    always_comb begin
        gnt_o = 2'b00;
        if (!rst_i) begin
            if (req_i == 2'b11) begin
                gnt_o = ptr_q ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    // Priority pointer register; port 0 has priority after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/flash_port_arb.sv
// flash_port_arb: arbitrates the instruction-fetch port (0) and the
// load/store port (1) onto the single-port flash array, and routes the
// 1-cycle read responses back to their owner.
// Optional write-protect window: define FLASH_ARB_WP_EN.
module flash_port_arb
    import flash_arb_pkg::*;
#(
    parameter int Width = 32,
    parameter int Depth = 8192,
    parameter int AddrW = 32,
`ifdef FLASH_ARB_WP_EN
    parameter int WpWords = 1024,
`endif
    localparam int Aw = $clog2(Depth)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               if_req_i,
    input  logic [AddrW-1:0]   if_addr_i,
    output logic               if_gnt_o,
    output logic               if_rvalid_o,
    output logic [Width-1:0]   if_rdata_o,
    output logic               if_err_o,
    input  logic               d_req_i,
    input  logic               d_we_i,
    input  logic [Width/8-1:0] d_be_i,
    input  logic [AddrW-1:0]   d_addr_i,
    input  logic [Width-1:0]   d_wdata_i,
    output logic               d_gnt_o,
    output logic               d_rvalid_o,
    output logic [Width-1:0]   d_rdata_o,
    output logic               d_err_o,
    output logic               fl_cs_o,
    output logic               fl_we_o,
    output logic [Width-1:0]   fl_wmask_o,
    output logic [Width-1:0]   fl_wdata_o,
    output logic [Aw-1:0]      fl_addr_o,
    input  logic [Width-1:0]   fl_dout_i,
    input  logic               fl_dvalid_i
`ifdef FLASH_ARB_WP_EN
   ,input  logic               wp_lock_i,
    output logic               wp_viol_o
`endif
);

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             any_gnt;
    logic             sel_d;
    logic             sel_we;
    logic [AddrW-1:0] sel_addr;
    logic [Aw-1:0]    sel_waddr;
    logic             addr_err;
    logic             be_zero;
    logic             wp_err;
    logic             issue;
    logic [Width-1:0] be_mask;
    rsp_tag_t         tag_d;
    rsp_tag_t         tag_q;
    logic             rsp_err;
    logic [Width-1:0] rsp_data;

    assign req = {d_req_i, if_req_i};

    flash_rr_arb u_rr_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign if_gnt_o = gnt[0];
    assign d_gnt_o  = gnt[1];
    assign any_gnt  = |gnt;

    for (genvar gi = 0; gi < Width / 8; gi++) begin : g_mask
        assign be_mask[gi*8 +: 8] = be_to_bitmask(d_be_i[gi]);
    end

    // Select the granted port's request and classify it.
    always_comb begin
        sel_d     = gnt[1];
        sel_addr  = sel_d ? d_addr_i : if_addr_i;
        sel_we    = sel_d & d_we_i;
        sel_waddr = sel_addr[Aw+1:2];
        addr_err  = (sel_addr[1:0] != 2'b00) | (sel_addr[AddrW-1:Aw+2] != '0);
        be_zero   = sel_we & (d_be_i == '0);
    end

`ifdef FLASH_ARB_WP_EN
    localparam logic [Aw:0] WpLimit = (Aw+1)'(WpWords);

    logic wp_viol_d;
    logic wp_viol_q;

    assign wp_err = sel_we & wp_lock_i & ~addr_err & ({1'b0, sel_waddr} < WpLimit);

    // Sticky flag for any write blocked by the protect window.
    always_comb begin
        wp_viol_d = wp_viol_q | (any_gnt & wp_err);
    end

    // Violation flag register; only reset clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_viol_q <= 1'b0;
        end else begin
            wp_viol_q <= wp_viol_d;
        end
    end

    assign wp_viol_o = wp_viol_q;
`else
    assign wp_err = 1'b0;
`endif

    // Error and empty-mask requests are acknowledged without touching flash.
    assign issue = any_gnt & ~addr_err & ~be_zero & ~wp_err;

    // Drive the flash macro from the granted port; quiet when not issuing.
    always_comb begin
        fl_cs_o    = issue;
        fl_we_o    = issue & sel_we;
        fl_addr_o  = issue ? sel_waddr : '0;
        fl_wmask_o = (issue & sel_we) ? be_mask : '0;
        fl_wdata_o = (issue & sel_we) ? d_wdata_i : '0;
    end

    // Build the response tag for the access granted this cycle.
    always_comb begin
        tag_d = '0;
        if (any_gnt) begin
            tag_d.valid    = 1'b1;
            tag_d.port     = sel_d ? PORT_D : PORT_IF;
            tag_d.is_write = sel_we;
            tag_d.err      = addr_err | wp_err;
        end
    end

    // One-deep response tag; a new grant overwrites it as the old one retires.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    // Route the response; a read the flash did not strobe becomes an error.
    always_comb begin
        rsp_err     = tag_q.err | (~tag_q.is_write & ~fl_dvalid_i);
        rsp_data    = (tag_q.is_write | rsp_err) ? '0 : fl_dout_i;
        if_rvalid_o = tag_q.valid & (tag_q.port == PORT_IF);
        d_rvalid_o  = tag_q.valid & (tag_q.port == PORT_D);
        if_rdata_o  = if_rvalid_o ? rsp_data : '0;
        d_rdata_o   = d_rvalid_o ? rsp_data : '0;
        if_err_o    = if_rvalid_o & rsp_err;
        d_err_o     = d_rvalid_o & rsp_err;
    end

endmodule

// File: tb/tb_flash_port_arb.sv
// tb_flash_port_arb: randomized scoreboard bench for flash_port_arb with a
// behavioural flash macro and a transaction-level reference model.
`timescale 1ns/1ps
module tb_flash_port_arb;

    localparam int W     = 32;
    localparam int DEPTH = 8192;
    localparam int AW    = 13;
    localparam int WPW   = 1024;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          if_req_i = 1'b0;
    logic [31:0]   if_addr_i = '0;
    logic          if_gnt_o, if_rvalid_o, if_err_o;
    logic [W-1:0]  if_rdata_o;
    logic          d_req_i = 1'b0, d_we_i = 1'b0;
    logic [3:0]    d_be_i = '0;
    logic [31:0]   d_addr_i = '0;
    logic [W-1:0]  d_wdata_i = '0;
    logic          d_gnt_o, d_rvalid_o, d_err_o;
    logic [W-1:0]  d_rdata_o;
    logic          fl_cs_o, fl_we_o;
    logic [W-1:0]  fl_wmask_o, fl_wdata_o;
    logic [AW-1:0] fl_addr_o;
    logic [W-1:0]  fl_dout_i = '0;
    logic          fl_dvalid_i = 1'b0;
    logic          fl_drop = 1'b0;
`ifdef FLASH_ARB_WP_EN
    logic          wp_lock_i = 1'b0;
    logic          wp_viol_o;
`endif

    flash_port_arb dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .if_err_o    (if_err_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_be_i      (d_be_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_gnt_o     (d_gnt_o),
        .d_rvalid_o  (d_rvalid_o),
        .d_rdata_o   (d_rdata_o),
        .d_err_o     (d_err_o),
        .fl_cs_o     (fl_cs_o),
        .fl_we_o     (fl_we_o),
        .fl_wmask_o  (fl_wmask_o),
        .fl_wdata_o  (fl_wdata_o),
        .fl_addr_o   (fl_addr_o),
        .fl_dout_i   (fl_dout_i),
        .fl_dvalid_i (fl_dvalid_i)
`ifdef FLASH_ARB_WP_EN
       ,.wp_lock_i   (wp_lock_i),
        .wp_viol_o   (wp_viol_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Flash macro model: masked write, 1-cycle read with a droppable strobe.
    logic [W-1:0] fmem [DEPTH];
    always @(posedge clk_i) begin
        if (fl_cs_o && fl_we_o)
            fmem[fl_addr_o] = (fmem[fl_addr_o] & ~fl_wmask_o) | (fl_wdata_o & fl_wmask_o);
        if (fl_cs_o && !fl_we_o)
            fl_dout_i <= fmem[fl_addr_o];
        fl_dvalid_i <= fl_cs_o && !fl_we_o && !fl_drop;
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference model state
    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } rsp_t;
    rsp_t         q0[$];
    rsp_t         q1[$];
    logic [W-1:0] ref_mem [DEPTH];
    int           last_gnt = 1;
    logic         exp_viol = 1'b0;
    int           n_vec = 0;
    int           n_mis = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive both ports, check grant and flash drive against
    // the model, and queue the expected response for the monitor.
    task automatic do_cycle(input logic ir, input logic [31:0] ia,
                            input logic dr, input logic dw, input logic [3:0] be,
                            input logic [31:0] da, input logic [31:0] wd,
                            input logic drop, input logic lock);
        int          p;
        logic [31:0] addr, mask;
        logic        we, aerr, wperr, access;
        int          widx;
        rsp_t        e;
        @(negedge clk_i);
        if_req_i = ir; if_addr_i = ia;
        d_req_i = dr; d_we_i = dw; d_be_i = be; d_addr_i = da; d_wdata_i = wd;
        fl_drop = drop;
`ifdef FLASH_ARB_WP_EN
        wp_lock_i = lock;
        chk1("wp_viol", wp_viol_o, exp_viol);
`endif
        #1;
        p = -1;
        if (ir && dr) p = (last_gnt == 0) ? 1 : 0;
        else if (ir)  p = 0;
        else if (dr)  p = 1;
        chk1("if_gnt", if_gnt_o, p == 0);
        chk1("d_gnt", d_gnt_o, p == 1);
        if (p < 0) begin
            chk1("idle_cs", fl_cs_o, 1'b0);
            return;
        end
        last_gnt = p;
        addr  = (p == 1) ? da : ia;
        we    = (p == 1) && dw;
        aerr  = (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
        widx  = int'(addr >> 2);
        wperr = 1'b0;
`ifdef FLASH_ARB_WP_EN
        wperr = lock && we && !aerr && (widx < WPW);
        if (wperr) exp_viol = 1'b1;
`endif
        access = !aerr && !wperr && !(we && be == 4'h0);
        mask = '0;
        for (int b = 0; b < 4; b++) if (be[b]) mask[8*b +: 8] = 8'hFF;
        chk1("fl_cs", fl_cs_o, access);
        if (access) begin
            chk32("fl_addr", 32'(fl_addr_o), 32'(widx));
            chk1("fl_we", fl_we_o, we);
            if (we) begin
                chk32("fl_wmask", fl_wmask_o, mask);
                chk32("fl_wdata", fl_wdata_o, wd);
            end
        end
        e.due = cyc + 1;
        if (we) begin
            e.err  = aerr || wperr;
            e.data = '0;
            if (access)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[widx][8*b +: 8] = wd[8*b +: 8];
        end else begin
            e.err  = aerr || drop;
            e.data = e.err ? 32'h0 : ref_mem[widx];
        end
        if (p == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Compare one port's response against the head of its queue.
    task automatic mon_port(input int p, input logic rv, input logic [31:0] rd, input logic er);
        rsp_t e;
        logic have;
        if (p == 0) have = (q0.size() > 0) && (q0[0].due <= cyc);
        else        have = (q1.size() > 0) && (q1[0].due <= cyc);
        chk1(p == 0 ? "if_rvalid" : "d_rvalid", rv, have);
        if (!have) return;
        if (p == 0) e = q0.pop_front(); else e = q1.pop_front();
        if (rv) begin
            chk1(p == 0 ? "if_err" : "d_err", er, e.err);
            if (!e.err) chk32(p == 0 ? "if_rdata" : "d_rdata", rd, e.data);
        end
    endtask

    // Monitor: sample responses just after each active edge.
    initial begin
        forever begin
            @(posedge clk_i);
            #2;
            mon_port(0, if_rvalid_o, if_rdata_o, if_err_o);
            mon_port(1, d_rvalid_o, d_rdata_o, d_err_o);
        end
    end

    task automatic enter_reset();
        rst_i = 1'b1;
        if_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
        q0.delete(); q1.delete();
        last_gnt = 1;
        exp_viol = 1'b0;
        #1;
        chk1("rst_gnt", if_gnt_o | d_gnt_o, 1'b0);
        chk1("rst_rvalid", if_rvalid_o | d_rvalid_o, 1'b0);
        chk1("rst_err", if_err_o | d_err_o, 1'b0);
        chk32("rst_rdata", if_rdata_o | d_rdata_o, 32'h0);
        chk1("rst_fl_ctl", fl_cs_o | fl_we_o, 1'b0);
        chk32("rst_fl_bus", fl_wmask_o | fl_wdata_o | 32'(fl_addr_o), 32'h0);
    endtask

    function automatic logic [31:0] rnd_addr();
        int          r;
        logic [31:0] a;
        r = int'($urandom_range(0, 15));
        a = 32'($urandom_range(0, 63)) << 2;
        if (r == 0)      a = a | 32'($urandom_range(1, 3));
        else if (r == 1) a = a | (32'h1 << $urandom_range(15, 31));
        return a;
    endfunction

    initial begin
        #150000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            fmem[i]    = 32'(i) * 32'h9E37_79B1;
            ref_mem[i] = 32'(i) * 32'h9E37_79B1;
        end
        #1;
        enter_reset();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // Full-word write then fetch of the same word
        do_cycle(0, 0, 1, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0);
        do_cycle(1, 32'h10, 0, 0, 4'h0, 0, 0, 0, 0);
        // Byte-lane merge
        do_cycle(0, 0, 1, 1, 4'hF, 32'h40, 32'h11223344, 0, 0);
        do_cycle(0, 0, 1, 1, 4'h2, 32'h40, 32'h0000AB00, 0, 0);
        do_cycle(0, 0, 1, 0, 4'hF, 32'h40, 0, 0, 0);
        chk32("merge_model", ref_mem[16], 32'h1122AB44);
        // Continuous contention
        for (int i = 0; i < 8; i++)
            do_cycle(1, 32'(i) << 2, 1, 0, 4'hF, 32'(i + 8) << 2, 0, 0, 0);
        // Misaligned and out-of-range fetches, empty-mask write, dropped strobe
        do_cycle(1, 32'h13, 0, 0, 4'h0, 0, 0, 0, 0);
        do_cycle(1, 32'h0001_0000, 0, 0, 4'h0, 0, 0, 0, 0);
        do_cycle(0, 0, 1, 1, 4'h0, 32'h20, 32'hFFFF_FFFF, 0, 0);
        do_cycle(0, 0, 1, 0, 4'hF, 32'h20, 0, 1, 0);
`ifdef FLASH_ARB_WP_EN
        // Protect window: blocked while locked, flag stays, passes when unlocked
        do_cycle(0, 0, 1, 1, 4'hF, 32'h100, 32'hCAFEF00D, 0, 1);
        do_cycle(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        do_cycle(0, 0, 1, 1, 4'hF, 32'h100, 32'hCAFEF00D, 0, 0);
        do_cycle(0, 0, 1, 0, 4'hF, 32'h100, 0, 0, 0);
`endif
        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            do_cycle(1'($urandom_range(0, 1)), rnd_addr(),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), rnd_addr(), $urandom(),
                     $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)));
        end
        // Reset while a load-store read is in flight
        do_cycle(0, 0, 1, 0, 4'hF, 32'h30, 0, 0, 0);
        enter_reset();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        do_cycle(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        do_cycle(1, 32'h8, 1, 0, 4'hF, 32'hC, 0, 0, 0);
        do_cycle(1, 32'h8, 1, 0, 4'hF, 32'hC, 0, 0, 0);
        // Drain
        repeat (4) do_cycle(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        chk32("drain_if_q", 32'(q0.size()), 32'h0);
        chk32("drain_d_q", 32'(q1.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/flash_port_arb.md
Name: flash_port_arb

Overview:
- Two-requester arbiter and sequencer in front of the single-port flash word array.
- Port 0 is the instruction fetch (read-only). Port 1 is the data/load-store port (read and byte-masked write).
- Translates byte addresses to word addresses, expands byte enables into the macro's bit-wide write mask, and routes each 1-cycle-latency read response back to the owning port.
- Sits between the core bus adapters and the flash macro in the SoC memory subsystem.

Parameters:
- Width, 32, data word width in bits; must be a multiple of 8.
- Depth, 8192, number of words in the flash array.
- AddrW, 32, requester byte-address width.
- Aw, $clog2(Depth), derived flash word-address width; not overridable.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous assert, active-high
- if_req_i  in  1  port-0 read request
- if_addr_i  in  AddrW  port-0 byte address
- if_gnt_o  out  1  port-0 request accepted this cycle
- if_rvalid_o  out  1  port-0 response valid
- if_rdata_o  out  Width  port-0 read data
- if_err_o  out  1  port-0 error, qualified by if_rvalid_o
- d_req_i  in  1  port-1 request
- d_we_i  in  1  port-1 write when 1
- d_be_i  in  Width/8  port-1 byte enables
- d_addr_i  in  AddrW  port-1 byte address
- d_wdata_i  in  Width  port-1 write data
- d_gnt_o  out  1  port-1 accepted
- d_rvalid_o  out  1  port-1 response valid; asserted for reads and writes
- d_rdata_o  out  Width  port-1 read data; 0 for writes
- d_err_o  out  1  port-1 error, qualified by d_rvalid_o
- fl_cs_o  out  1  flash chip select
- fl_we_o  out  1  flash write enable
- fl_wmask_o  out  Width  flash bit mask; bit i = d_be_i[i/8]
- fl_wdata_o  out  Width  flash write data
- fl_addr_o  out  Aw  flash word address = byte_addr[Aw+1:2]
- fl_dout_i  in  Width  flash read data
- fl_dvalid_i  in  1  flash read-valid strobe, 1 cycle after a read cs

Behaviour:
- Reset: all outputs 0; round-robin pointer = port 0; response pipeline empty.
- Grant is combinational. At most one of if_gnt_o/d_gnt_o is high per cycle. A grant is issued the same cycle req is seen.
- Arbitration when both ports request: round-robin. Priority goes to the port that was not granted most recently. The pointer updates only on a grant.
- Single requester: granted every cycle. Throughput is one access per cycle and fully pipelined.
- Flash drive on grant: fl_cs_o=1; fl_addr_o, fl_we_o, fl_wmask_o and fl_wdata_o come from the granted port. Port 0 always drives we=0.
- Response timing: exactly 1 cycle after grant, rvalid is asserted on the granted port.
- Response data: read data = fl_dout_i. Write responses carry rdata=0 and err=0.
- Response routing: a 1-deep registered tag records {valid, port, is_write, err}.
- fl_dvalid_i is checked against the tag for reads. A mismatch (dvalid=0 on an expected read) raises err on that response.
- Error, misaligned address (addr[1:0]!=0): granted, no flash access (fl_cs_o=0), err response next cycle.
- Error, out of range (addr[AddrW-1:Aw+2] != 0): handled the same as misaligned.
- Write with d_be_i == 0: granted and acknowledged; fl_cs_o=0.
- Simultaneous response and new grant: allowed. The tag register is overwritten with the new grant in the same edge that emits the old response.
- Reset mid-operation: the pending response is dropped and no rvalid is emitted after reset. Requesters must re-issue.
- No combinational path from any rvalid to any gnt.

Optional Feature:
- Macro: FLASH_ARB_WP_EN.
- Enabled:
  - Adds parameter WpWords (default 1024) and input wp_lock_i.
  - While wp_lock_i=1, writes to word addresses < WpWords are granted but not issued (fl_cs_o=0) and respond with d_err_o=1.
  - A sticky output wp_viol_o sets on such a write and clears only on reset.
- Disabled: no port, no parameter; all in-range writes proceed.

Decomposition:
- Package flash_arb_pkg:
  - typedef port_e {PORT_IF=0, PORT_D=1}.
  - struct rsp_tag_t {valid, port, is_write, err}.
  - function be_to_bitmask().
- Sub-module flash_rr_arb: 2-input round-robin arbiter (req[1:0] -> gnt[1:0], pointer register). Everything else is top-level.

Test Plan:
- Port 1 writes 0xDEADBEEF at 0x10 with be=0xF, then port 0 reads 0x10 -> fl_addr_o=4, fl_wmask_o=0xFFFFFFFF; if_rdata_o=0xDEADBEEF one cycle after if_gnt_o; errs 0.
- Both ports request every cycle for 8 cycles -> grants alternate 0,1,0,1…; each rvalid lands on the matching port 1 cycle later with correct data.
- Port 1 write be=0x2 data 0x0000AB00 over 0x11223344 -> next read returns 0x1122AB44; fl_wmask_o=0x0000FF00.
- Port 0 reads 0x13 (misaligned) and 0x00010000 (out of range for Depth=8192) -> fl_cs_o=0 both; if_err_o=1 on each response.
- Assert rst_i the cycle after a port 1 read grant -> no d_rvalid_o after reset; all outputs 0; first post-reset contention grants port 0.
- With FLASH_ARB_WP_EN and wp_lock_i=1: write to 0x100 -> d_err_o=1, fl_cs_o=0, wp_viol_o=1 and stays set. Lock=0: same write succeeds.
